// File: rtl/windowed_reg_file.sv
// SPARC windowed integer register file: physical storage, logical-to-physical
// window mapping, CWP/WIM state and registered window overflow/underflow pulses.
module windowed_reg_file #(
    parameter int unsigned NWIN  = 4,
    parameter int unsigned CWP_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ra,
    input  logic [4:0]       rb,
    input  logic [4:0]       rc,
    output logic [31:0]      pa,
    output logic [31:0]      pb,
    output logic [31:0]      pc,
    input  logic [4:0]       rd,
    input  logic [31:0]      wd,
    input  logic             we,
    input  logic             save,
    input  logic             restore,
    input  logic             cwp_we,
    input  logic [CWP_W-1:0] cwp_in,
    input  logic             wim_we,
    input  logic [NWIN-1:0]  wim_in,
    output logic [CWP_W-1:0] cwp,
    output logic [NWIN-1:0]  wim,
    output logic             win_ovf,
    output logic             win_unf
);

    localparam int unsigned NPHYS = 8 + 16 * NWIN;
    localparam int unsigned PW    = $clog2(NPHYS);

    logic [31:0]      r_regs [NPHYS];
    logic [CWP_W-1:0] r_cwp;
    logic [NWIN-1:0]  r_wim;
    logic             r_ovf;
    logic             r_unf;

    logic [CWP_W-1:0] w_cwp_dec;
    logic [CWP_W-1:0] w_cwp_inc;
    logic [CWP_W-1:0] w_cwp_nxt;
    logic [CWP_W-1:0] w_wr_win;
    logic             w_dec_inv;
    logic             w_inc_inv;
    logic             w_ovf;
    logic             w_unf;
    logic             w_wr_en;

    // Outs of window w are the ins of window (w-1) mod NWIN.
    function automatic logic [PW-1:0] phys_idx(input logic [4:0] r, input logic [CWP_W-1:0] w);
        int unsigned wi;
        int unsigned ri;
        int unsigned wp;
        int unsigned idx;
        wi = 32'(w);
        ri = 32'(r);
        wp = (wi == 0) ? NWIN - 1 : wi - 1;
        if (ri < 8) begin
            idx = ri;
        end else if (ri >= 24) begin
            idx = 8 + 16 * wi + (ri - 24);
        end else if (ri >= 16) begin
            idx = 8 + 16 * wi + 8 + (ri - 16);
        end else begin
            idx = 8 + 16 * wp + (ri - 8);
        end
        return PW'(idx);
    endfunction

    always_comb begin
        w_cwp_dec = (r_cwp == '0) ? CWP_W'(NWIN - 1) : r_cwp - CWP_W'(1);
        w_cwp_inc = (r_cwp == CWP_W'(NWIN - 1)) ? '0 : r_cwp + CWP_W'(1);
        w_dec_inv = |(r_wim & (NWIN'(1) << w_cwp_dec));
        w_inc_inv = |(r_wim & (NWIN'(1) << w_cwp_inc));
        w_cwp_nxt = r_cwp;
        w_wr_win  = r_cwp;
        w_ovf     = 1'b0;
        w_unf     = 1'b0;
        if (cwp_we) begin
            if (32'(cwp_in) < NWIN) begin
                w_cwp_nxt = cwp_in;
            end
        end else if (save && !restore) begin
            if (w_dec_inv) begin
                w_ovf = 1'b1;
            end else begin
                w_cwp_nxt = w_cwp_dec;
                w_wr_win  = w_cwp_dec;
            end
        end else if (restore && !save) begin
            if (w_inc_inv) begin
                w_unf = 1'b1;
            end else begin
                w_cwp_nxt = w_cwp_inc;
                w_wr_win  = w_cwp_inc;
            end
        end
        // A trapping window move kills the write-back of the same instruction.
        w_wr_en = we && (rd != 5'd0) && !w_ovf && !w_unf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NPHYS; i++) begin
                r_regs[i] <= '0;
            end
            r_cwp <= '0;
            r_wim <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_regs[phys_idx(rd, w_wr_win)] <= wd;
            end
            r_cwp <= w_cwp_nxt;
            if (wim_we) begin
                r_wim <= wim_in;
            end
            r_ovf <= w_ovf;
            r_unf <= w_unf;
        end
    end

    assign pa      = (ra == 5'd0) ? '0 : r_regs[phys_idx(ra, r_cwp)];
    assign pb      = (rb == 5'd0) ? '0 : r_regs[phys_idx(rb, r_cwp)];
    assign pc      = (rc == 5'd0) ? '0 : r_regs[phys_idx(rc, r_cwp)];
    assign cwp     = r_cwp;
    assign wim     = r_wim;
    assign win_ovf = r_ovf;
    assign win_unf = r_unf;

endmodule

// File: tb/tb_windowed_reg_file.sv
// Directed vector bench for windowed_reg_file with NWIN=4, CWP_W=3 so that
// out-of-range direct CWP loads can be exercised.
module tb_windowed_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra, rb, rc, rd;
    logic [31:0] pa, pb, pc, wd;
    logic        we, save, restore, cwp_we, wim_we;
    logic [2:0]  cwp_in, cwp;
    logic [3:0]  wim_in, wim;
    logic        win_ovf, win_unf;

    int total = 0;
    int bad   = 0;

    windowed_reg_file #(.NWIN(4), .CWP_W(3)) dut (
        .clk(clk), .rst(rst),
        .ra(ra), .rb(rb), .rc(rc),
        .pa(pa), .pb(pb), .pc(pc),
        .rd(rd), .wd(wd), .we(we),
        .save(save), .restore(restore),
        .cwp_we(cwp_we), .cwp_in(cwp_in),
        .wim_we(wim_we), .wim_in(wim_in),
        .cwp(cwp), .wim(wim),
        .win_ovf(win_ovf), .win_unf(win_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        sv;
        logic        rs;
        logic        cwe;
        logic [2:0]  cin;
        logic        wwe;
        logic [3:0]  win;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rc;
        logic [31:0] xa;
        logic [31:0] xb;
        logic [31:0] xc;
        logic [2:0]  xcwp;
        logic [3:0]  xwim;
        logic        xo;
        logic        xu;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 0; we = 0; rd = 0; wd = 0; save = 0; restore = 0;
        cwp_we = 0; cwp_in = 0; wim_we = 0; wim_in = 0;
    endtask

    initial begin
        idle_inputs();
        ra = 0; rb = 0; rc = 0;

        //          rst we rd  wd            sv rs cwe cin wwe win      ra  rb  rc  xa            xb            xc            cwp wim      o  u
        vecs.push_back('{1, 0, 0,  32'h0,        0, 0, 0, 0, 0, 4'b0000, 1,  0,  8,  32'h0,        32'h0,        32'h0,        0, 4'b0000, 0, 0});
        vecs.push_back('{0, 1, 1,  32'hDEADBEEF, 0, 0, 0, 0, 0, 4'b0000, 1,  0,  1,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0, 4'b0000, 0, 0});
        vecs.push_back('{0, 1, 0,  32'h12345678, 0, 0, 0, 0, 0, 4'b0000, 1,  0,  0,  32'hDEADBEEF, 32'h0,        32'h0,        0, 4'b0000, 0, 0});
        vecs.push_back('{0, 1, 8,  32'hA5A5A5A5, 0, 0, 0, 0, 0, 4'b0000, 8,  24, 16, 32'hA5A5A5A5, 32'h0,        32'h0,        0, 4'b0000, 0, 0});
        vecs.push_back('{0, 0, 0,  32'h0,        0, 1, 0, 0, 0, 4'b0000, 8,  24, 1,  32'h0,        32'h0,        32'hDEADBEEF, 1, 4'b0000, 0, 0});
        vecs.push_back('{0, 0, 0,  32'h0,        1, 0, 0, 0, 0, 4'b0000, 8,  0,  1,  32'hA5A5A5A5, 32'h0,        32'hDEADBEEF, 0, 4'b0000, 0, 0});
        vecs.push_back('{0, 0, 0,  32'h0,        1, 0, 0, 0, 0, 4'b0000, 24, 8,  16, 32'hA5A5A5A5, 32'h0,        32'h0,        3, 4'b0000, 0, 0});
        vecs.push_back('{0, 0, 0,  32'h0,        0, 1, 0, 0, 0, 4'b0000, 8,  0,  0,  32'hA5A5A5A5, 32'h0,        32'h0,        0, 4'b0000, 0, 0});
        vecs.push_back('{0, 0, 0,  32'h0,        0, 0, 0, 0, 1, 4'b1000, 0,  0,  0,  32'h0,        32'h0,        32'h0,        0, 4'b1000, 0, 0});
        vecs.push_back('{0, 1, 16, 32'h5,        1, 0, 0, 0, 0, 4'b0000, 16, 0,  0,  32'h0,        32'h0,        32'h0,        0, 4'b1000, 1, 0});
        vecs.push_back('{0, 0, 0,  32'h0,        0, 0, 0, 0, 0, 4'b0000, 16, 0,  0,  32'h0,        32'h0,        32'h0,        0, 4'b1000, 0, 0});
        vecs.push_back('{0, 0, 0,  32'h0,        0, 0, 1, 3, 0, 4'b0000, 16, 0,  0,  32'h0,        32'h0,        32'h0,        3, 4'b1000, 0, 0});
        vecs.push_back('{0, 0, 0,  32'h0,        0, 0, 1, 0, 0, 4'b0000, 0,  0,  0,  32'h0,        32'h0,        32'h0,        0, 4'b1000, 0, 0});
        vecs.push_back('{0, 0, 0,  32'h0,        0, 0, 0, 0, 1, 4'b0000, 0,  0,  0,  32'h0,        32'h0,        32'h0,        0, 4'b0000, 0, 0});
        vecs.push_back('{0, 1, 16, 32'h7,        1, 0, 0, 0, 0, 4'b0000, 16, 0,  0,  32'h7,        32'h0,        32'h0,        3, 4'b0000, 0, 0});
        vecs.push_back('{0, 0, 0,  32'h0,        0, 1, 0, 0, 0, 4'b0000, 16, 0,  0,  32'h0,        32'h0,        32'h0,        0, 4'b0000, 0, 0});
        vecs.push_back('{0, 0, 0,  32'h0,        0, 0, 0, 0, 1, 4'b0010, 0,  0,  0,  32'h0,        32'h0,        32'h0,        0, 4'b0010, 0, 0});
        vecs.push_back('{0, 1, 17, 32'h9,        0, 1, 0, 0, 0, 4'b0000, 17, 0,  0,  32'h0,        32'h0,        32'h0,        0, 4'b0010, 0, 1});
        vecs.push_back('{0, 0, 0,  32'h0,        0, 1, 0, 0, 0, 4'b0000, 17, 0,  0,  32'h0,        32'h0,        32'h0,        0, 4'b0010, 0, 1});
        vecs.push_back('{0, 0, 0,  32'h0,        1, 0, 0, 0, 0, 4'b0000, 17, 0,  0,  32'h0,        32'h0,        32'h0,        3, 4'b0010, 0, 0});
        vecs.push_back('{0, 0, 0,  32'h0,        0, 0, 1, 5, 0, 4'b0000, 0,  0,  0,  32'h0,        32'h0,        32'h0,        3, 4'b0010, 0, 0});
        vecs.push_back('{0, 0, 0,  32'h0,        1, 0, 1, 2, 0, 4'b0000, 0,  0,  0,  32'h0,        32'h0,        32'h0,        2, 4'b0010, 0, 0});
        vecs.push_back('{0, 1, 24, 32'h11,       0, 1, 1, 1, 0, 4'b0000, 24, 8,  0,  32'h0,        32'h0,        32'h0,        1, 4'b0010, 0, 0});
        vecs.push_back('{0, 1, 25, 32'h22,       1, 1, 0, 0, 0, 4'b0000, 25, 24, 0,  32'h22,       32'h0,        32'h0,        1, 4'b0010, 0, 0});
        vecs.push_back('{0, 0, 0,  32'h0,        0, 0, 1, 3, 0, 4'b0000, 8,  25, 24, 32'h11,       32'h0,        32'hA5A5A5A5, 3, 4'b0010, 0, 0});
        vecs.push_back('{0, 0, 0,  32'h0,        1, 0, 0, 0, 1, 4'b0100, 0,  0,  0,  32'h0,        32'h0,        32'h0,        2, 4'b0100, 0, 0});
        vecs.push_back('{0, 0, 0,  32'h0,        0, 1, 0, 0, 0, 4'b0000, 0,  0,  0,  32'h0,        32'h0,        32'h0,        3, 4'b0100, 0, 0});
        vecs.push_back('{0, 0, 0,  32'h0,        1, 0, 0, 0, 0, 4'b0000, 24, 0,  0,  32'hA5A5A5A5, 32'h0,        32'h0,        3, 4'b0100, 1, 0});
        vecs.push_back('{1, 1, 1,  32'hFFFFFFFF, 1, 0, 1, 2, 1, 4'b1111, 1,  24, 16, 32'h0,        32'h0,        32'h0,        0, 4'b0000, 0, 0});
        vecs.push_back('{0, 0, 0,  32'h0,        0, 0, 0, 0, 0, 4'b0000, 1,  8,  25, 32'h0,        32'h0,        32'h0,        0, 4'b0000, 0, 0});

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; we = vecs[i].we; rd = vecs[i].rd; wd = vecs[i].wd;
            save = vecs[i].sv; restore = vecs[i].rs;
            cwp_we = vecs[i].cwe; cwp_in = vecs[i].cin;
            wim_we = vecs[i].wwe; wim_in = vecs[i].win;
            ra = vecs[i].ra; rb = vecs[i].rb; rc = vecs[i].rc;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d pa", i), pa, vecs[i].xa);
            chk($sformatf("v%0d pb", i), pb, vecs[i].xb);
            chk($sformatf("v%0d pc", i), pc, vecs[i].xc);
            chk($sformatf("v%0d cwp", i), 32'(cwp), 32'(vecs[i].xcwp));
            chk($sformatf("v%0d wim", i), 32'(wim), 32'(vecs[i].xwim));
            chk($sformatf("v%0d ovf", i), 32'(win_ovf), 32'(vecs[i].xo));
            chk($sformatf("v%0d unf", i), 32'(win_unf), 32'(vecs[i].xu));
        end

        // Read during write returns the old value until the edge.
        @(negedge clk);
        idle_inputs();
        we = 1; rd = 5; wd = 32'hCAFEF00D; ra = 5;
        #1;
        chk("rdw old", pa, 32'h0);
        @(posedge clk);
        #1;
        chk("rdw new", pa, 32'hCAFEF00D);

        // Overflow pulse is exactly one cycle wide.
        @(negedge clk);
        idle_inputs();
        wim_we = 1; wim_in = 4'b1000;
        @(negedge clk);
        idle_inputs();
        save = 1;
        @(negedge clk);
        idle_inputs();
        chk("ovf pulse", 32'(win_ovf), 32'h1);
        chk("ovf no unf", 32'(win_unf), 32'h0);
        chk("ovf cwp", 32'(cwp), 32'h0);
        @(negedge clk);
        chk("ovf clear", 32'(win_ovf), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
